// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous two lines. Each processed position
// (real pixel, or virtual pixel during a flush) shifts one new column into
// a 3x3 register window. A window is emitted when the shifted-in column
// completes a window whose centre is one row and one column behind.
// BORDER_MODE 0 crops the border. BORDER_MODE 1 zero-pads it by walking
// one virtual column per line and one virtual line per frame.

module line_window_3x3 #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned IMG_W       = 640,
    parameter int unsigned IMG_H       = 512,
    parameter int unsigned BORDER_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eol,
    output logic                out_eof,
    output logic [9*DATA_W-1:0] out_win,
    output logic                err
);

    localparam int unsigned CW  = $clog2(IMG_W + 1);
    localparam int unsigned RW  = $clog2(IMG_H + 1);
    localparam int unsigned AW  = $clog2(IMG_W);
    localparam bit          PAD = (BORDER_MODE != 0);

    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_VIRT = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_VIRT = RW'(IMG_H);

    typedef enum logic [1:0] {StIdle, StRun, StColFlush, StRowFlush} state_t;

    state_t              r_state;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic                r_ready;
    logic                r_err;
    logic                r_out_valid;
    logic                r_out_sof;
    logic                r_out_eol;
    logic                r_out_eof;
    logic [9*DATA_W-1:0] r_out_win;
    logic [DATA_W-1:0]   r_lb1 [IMG_W];  // line r-1 relative to the incoming line
    logic [DATA_W-1:0]   r_lb2 [IMG_W];  // line r-2
    logic [DATA_W-1:0]   r_win [3][3];   // [row][col], col 2 is the newest

    logic                w_acc;
    logic                w_proc;
    logic                w_restart;
    logic                w_real;
    logic                w_emit;
    logic                w_sof;
    logic                w_eol;
    logic                w_eof;
    logic [RW-1:0]       w_prow;
    logic [CW-1:0]       w_pcol;
    logic [AW-1:0]       w_addr;
    logic [DATA_W-1:0]   w_top;
    logic [DATA_W-1:0]   w_mid;
    logic [DATA_W-1:0]   w_bot;
    logic [DATA_W-1:0]   w_win_n [3][3];
    logic [9*DATA_W-1:0] w_win_flat;

    // Decide whether a position is processed this cycle, and which one.
    always_comb begin
        w_acc     = in_valid && r_ready;
        w_proc    = 1'b0;
        w_restart = 1'b0;
        w_prow    = '0;
        w_pcol    = '0;
        case (r_state)
            StIdle: begin
                if (w_acc && in_sof) begin
                    w_proc    = 1'b1;
                    w_restart = 1'b1;
                end
            end
            StRun: begin
                if (w_acc) begin
                    w_proc = 1'b1;
                    if (in_sof) begin
                        w_restart = 1'b1;
                    end else begin
                        w_prow = r_row;
                        w_pcol = r_col;
                    end
                end
            end
            StColFlush: begin
                w_proc = 1'b1;
                w_prow = r_row;
                w_pcol = COL_VIRT;
            end
            StRowFlush: begin
                w_proc = 1'b1;
                w_prow = ROW_VIRT;
                w_pcol = r_col;
            end
            default: ;
        endcase
    end

    // New column taps; anything outside the image (incl. stale RAM) reads as zero.
    always_comb begin
        w_real = (w_prow < ROW_VIRT) && (w_pcol < COL_VIRT);
        w_addr = w_pcol[AW-1:0];
        w_top  = '0;
        w_mid  = '0;
        w_bot  = '0;
        if (w_pcol < COL_VIRT) begin
            if (w_prow >= ROW_TWO) w_top = r_lb2[w_addr];
            if (w_prow >= ROW_ONE) w_mid = r_lb1[w_addr];
        end
        if (w_real) w_bot = in_data;
    end

    // Shifted window and its flat packing (p11 in the LSBs).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_win_n[i][0] = r_win[i][1];
            w_win_n[i][1] = r_win[i][2];
        end
        w_win_n[0][2] = w_top;
        w_win_n[1][2] = w_mid;
        w_win_n[2][2] = w_bot;
        w_win_flat = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_win_flat[(i*3+j)*DATA_W +: DATA_W] = w_win_n[i][j];
            end
        end
    end

    // Emit when the processed position is one row and column past an output centre.
    always_comb begin
        if (PAD) begin
            w_emit = w_proc && (w_prow >= ROW_ONE) && (w_pcol >= COL_ONE);
            w_sof  = (w_prow == ROW_ONE) && (w_pcol == COL_ONE);
            w_eol  = (w_pcol == COL_VIRT);
            w_eof  = w_eol && (w_prow == ROW_VIRT);
        end else begin
            w_emit = w_proc && (w_prow >= ROW_TWO) && (w_pcol >= COL_TWO);
            w_sof  = (w_prow == ROW_TWO) && (w_pcol == COL_TWO);
            w_eol  = (w_pcol == COL_LAST);
            w_eof  = w_eol && (w_prow == ROW_LAST);
        end
    end

    // Control FSM: position counters, registered in_ready and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_row   <= '0;
            r_col   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= (r_state == StRun) && w_acc && in_sof;
            r_ready <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (w_proc) begin
                        r_state <= StRun;
                        r_row   <= '0;
                        r_col   <= COL_ONE;
                    end
                end
                StRun: begin
                    if (w_proc) begin
                        if (w_restart) begin
                            // Abandon the current frame; this pixel is (0,0).
                            r_row <= '0;
                            r_col <= COL_ONE;
                        end else if (r_col == COL_LAST) begin
                            if (PAD) begin
                                r_state <= StColFlush;
                                r_col   <= COL_VIRT;
                                r_ready <= 1'b0;
                            end else if (r_row == ROW_LAST) begin
                                r_state <= StIdle;
                                r_row   <= '0;
                                r_col   <= '0;
                            end else begin
                                r_row <= r_row + ROW_ONE;
                                r_col <= '0;
                            end
                        end else begin
                            r_col <= r_col + COL_ONE;
                        end
                    end
                end
                StColFlush: begin
                    r_col <= '0;
                    if (r_row == ROW_LAST) begin
                        r_state <= StRowFlush;
                        r_row   <= ROW_VIRT;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= StRun;
                        r_row   <= r_row + ROW_ONE;
                    end
                end
                StRowFlush: begin
                    if (r_col == COL_VIRT) begin
                        r_state <= StIdle;
                        r_row   <= '0;
                        r_col   <= '0;
                    end else begin
                        r_col   <= r_col + COL_ONE;
                        r_ready <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Line buffers: push the real pixel down one line at its column.
    always_ff @(posedge clk) begin
        if (w_proc && w_real) begin
            r_lb2[w_addr] <= r_lb1[w_addr];
            r_lb1[w_addr] <= w_bot;
        end
    end

    // Window registers shift once per processed position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_proc) begin
            r_win <= w_win_n;
        end
    end

    // Output registers; out_win only changes on a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_win   <= '0;
        end else begin
            r_out_valid <= w_emit;
            r_out_sof   <= w_emit && w_sof;
            r_out_eol   <= w_emit && w_eol;
            r_out_eof   <= w_emit && w_eof;
            if (w_emit) r_out_win <= w_win_flat;
        end
    end

    assign in_ready  = r_ready;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;
    assign out_win   = r_out_win;
    assign err       = r_err;

endmodule

// File: tb/tb_line_window_3x3.sv
// Bench for line_window_3x3: one crop and one zero-pad instance on a 4x3 image.
// Expected windows come from a direct tap model (out-of-image taps are zero).

module tb_line_window_3x3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int WW = 9 * DW;

    localparam logic [WW-1:0] CROP_FIRST = 72'h16_15_14_0C_0B_0A_02_01_00;
    localparam logic [WW-1:0] CROP_LAST  = 72'h17_16_15_0D_0C_0B_03_02_01;
    localparam logic [WW-1:0] PAD_FIRST  = 72'h0B_0A_00_01_00_00_00_00_00;
    localparam logic [WW-1:0] PAD_LAST   = 72'h00_00_00_00_17_16_00_0D_0C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          c_valid = 1'b0, c_sof = 1'b0;
    logic [DW-1:0] c_data  = '0;
    logic          c_ready, c_ovalid, c_osof, c_oeol, c_oeof, c_err;
    logic [WW-1:0] c_owin;
    logic          p_valid = 1'b0, p_sof = 1'b0;
    logic [DW-1:0] p_data  = '0;
    logic          p_ready, p_ovalid, p_osof, p_oeol, p_oeof, p_err;
    logic [WW-1:0] p_owin;

    line_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) u_crop (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_sof(c_sof), .in_data(c_data),
        .in_ready(c_ready), .out_valid(c_ovalid), .out_sof(c_osof), .out_eol(c_oeol),
        .out_eof(c_oeof), .out_win(c_owin), .err(c_err)
    );

    line_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) u_pad (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_sof(p_sof), .in_data(p_data),
        .in_ready(p_ready), .out_valid(p_ovalid), .out_sof(p_osof), .out_eol(p_oeol),
        .out_eof(p_oeof), .out_win(p_owin), .err(p_err)
    );

    typedef struct {
        logic [WW-1:0] win;
        logic [2:0]    flags;  // {sof, eol, eof}
        int            stamp;
    } rec_t;

    typedef struct {
        bit            pad;
        int            gapmode;  // 0 continuous, 1 valid 1,0,0,1..., 2 random gaps
        bit            rnd;
        int            base;
        int            n_win;
        int            n_low;
        bit            chk;
        logic [WW-1:0] first;
        logic [WW-1:0] last;
    } vec_t;

    rec_t c_q[$];
    rec_t p_q[$];
    vec_t tbl [6];
    int   n_edge = 0;
    int   c_errs = 0, p_errs = 0, c_err_stamp = -1;
    int   c_low = 0, p_low = 0;
    int   n_checks = 0, n_fail = 0;
    logic [DW-1:0] img [H][W];
    int   acc [H][W];

    always @(posedge clk) n_edge <= n_edge + 1;

    // Collect windows, error pulses and in_ready-low cycles mid-cycle.
    always @(negedge clk) begin
        if (c_ovalid) c_q.push_back('{c_owin, {c_osof, c_oeol, c_oeof}, n_edge});
        if (p_ovalid) p_q.push_back('{p_owin, {p_osof, p_oeol, p_oeof}, n_edge});
        if (c_err) begin
            c_errs      <= c_errs + 1;
            c_err_stamp <= n_edge;
        end
        if (p_err) p_errs <= p_errs + 1;
        if (!rst && !c_ready) c_low <= c_low + 1;
        if (!rst && !p_ready) p_low <= p_low + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic int qsize(input bit pad);
        return pad ? p_q.size() : c_q.size();
    endfunction

    function automatic rec_t qget(input bit pad, input int k);
        return pad ? p_q[k] : c_q[k];
    endfunction

    function automatic logic rdy(input bit pad);
        return pad ? p_ready : c_ready;
    endfunction

    function automatic logic [DW-1:0] tap(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return '0;
        return img[r][c];
    endfunction

    function automatic logic [WW-1:0] model_win(input int r, input int c);
        logic [WW-1:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*DW +: DW] = tap(r - 1 + i, c - 1 + j);
        return w;
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act,
                         input logic [WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit pad, input logic v, input logic s, input logic [DW-1:0] d);
        if (pad) begin
            p_valid = v; p_sof = s; p_data = d;
        end else begin
            c_valid = v; c_sof = s; c_data = d;
        end
    endtask

    task automatic send_pixel(input bit pad, input logic s, input logic [DW-1:0] d,
                              input int gap, output int stamp);
        int guard = 0;
        repeat (gap) begin @(posedge clk); #1; end
        drive(pad, 1'b1, s, d);
        while (!rdy(pad) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait_timeout", WW'(guard >= 100), '0);
        @(posedge clk); #1;
        stamp = n_edge;
        drive(pad, 1'b0, 1'b0, '0);
    endtask

    task automatic run_frame(input bit pad, input int gapmode);
        int gap;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gapmode == 0 || (r == 0 && c == 0)) gap = 0;
                else if (gapmode == 1) gap = 2;
                else gap = int'($urandom_range(0, 2));
                send_pixel(pad, (r == 0 && c == 0), img[r][c], gap, acc[r][c]);
            end
        end
    endtask

    task automatic wait_windows(input bit pad, input int n);
        int g = 0;
        while (qsize(pad) < n && g < 80) begin
            @(posedge clk); #1;
            g++;
        end
        check("window_wait_timeout", WW'(g >= 80), '0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic check_frame(input bit pad, input int n_exp, input string tag);
        rec_t got;
        int   k = 0;
        int   rlo = pad ? 0 : 1;
        int   rhi = pad ? H - 1 : H - 2;
        int   clo = pad ? 0 : 1;
        int   chi = pad ? W - 1 : W - 2;
        check({tag, " count"}, WW'(qsize(pad)), WW'(n_exp));
        for (int r = rlo; r <= rhi; r++) begin
            for (int c = clo; c <= chi; c++) begin
                if (k < qsize(pad)) begin
                    got = qget(pad, k);
                    check($sformatf("%s win(%0d,%0d)", tag, r, c), got.win, model_win(r, c));
                    check($sformatf("%s flags(%0d,%0d)", tag, r, c), WW'(got.flags),
                          WW'({(r == rlo && c == clo), (c == chi), (c == chi && r == rhi)}));
                    if (r + 1 < H && c + 1 < W)
                        check($sformatf("%s latency(%0d,%0d)", tag, r, c),
                              WW'(got.stamp), WW'(acc[r+1][c+1]));
                end
                k++;
            end
        end
    endtask

    task automatic fill_img(input bit rnd, input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd ? DW'($urandom_range(0, 255)) : DW'(base + 10 * r + c);
    endtask

    initial begin
        int low0, err0, st;
        logic [WW-1:0] hold_exp;
        rec_t got;

        tbl[0] = '{1'b0, 0, 1'b0, 0,   2,  0, 1'b1, CROP_FIRST, CROP_LAST};
        tbl[1] = '{1'b1, 0, 1'b0, 0,   12, 8, 1'b1, PAD_FIRST,  PAD_LAST};
        tbl[2] = '{1'b1, 1, 1'b0, 0,   12, 8, 1'b1, PAD_FIRST,  PAD_LAST};
        tbl[3] = '{1'b1, 0, 1'b0, 200, 12, 8, 1'b0, '0, '0};
        tbl[4] = '{1'b0, 2, 1'b1, 0,   2,  0, 1'b0, '0, '0};
        tbl[5] = '{1'b1, 2, 1'b1, 0,   12, 8, 1'b0, '0, '0};

        // Reset state
        repeat (2) begin @(posedge clk); #1; end
        check("rst c_ready", WW'(c_ready), '0);
        check("rst p_ready", WW'(p_ready), '0);
        check("rst outs", WW'({c_ovalid, c_osof, c_oeol, c_oeof, c_err,
                               p_ovalid, p_osof, p_oeol, p_oeof, p_err}), '0);
        check("rst c_win", c_owin, '0);
        check("rst p_win", p_owin, '0);
        rst = 1'b0;
        check("release c_ready", WW'(c_ready), '0);
        @(posedge clk); #1;
        check("post c_ready", WW'(c_ready), WW'(1));
        check("post p_ready", WW'(p_ready), WW'(1));

        // Table-driven frames
        for (int t = 0; t < 6; t++) begin
            fill_img(tbl[t].rnd, tbl[t].base);
            c_q.delete();
            p_q.delete();
            low0 = tbl[t].pad ? p_low : c_low;
            err0 = tbl[t].pad ? p_errs : c_errs;
            run_frame(tbl[t].pad, tbl[t].gapmode);
            wait_windows(tbl[t].pad, tbl[t].n_win);
            check_frame(tbl[t].pad, tbl[t].n_win, $sformatf("vec%0d", t));
            check($sformatf("vec%0d ready_low", t),
                  WW'((tbl[t].pad ? p_low : c_low) - low0), WW'(tbl[t].n_low));
            check($sformatf("vec%0d err", t),
                  WW'((tbl[t].pad ? p_errs : c_errs) - err0), '0);
            hold_exp = tbl[t].pad ? model_win(H - 1, W - 1) : model_win(H - 2, W - 2);
            check($sformatf("vec%0d hold", t), tbl[t].pad ? p_owin : c_owin, hold_exp);
            if (tbl[t].chk && qsize(tbl[t].pad) == tbl[t].n_win) begin
                got = qget(tbl[t].pad, 0);
                check($sformatf("vec%0d first", t), got.win, tbl[t].first);
                got = qget(tbl[t].pad, tbl[t].n_win - 1);
                check($sformatf("vec%0d last", t), got.win, tbl[t].last);
            end
        end

        // in_sof while running: error pulse, restart as a new frame
        fill_img(1'b0, 0);
        c_q.delete();
        err0 = c_errs;
        for (int k = 0; k < 6; k++) send_pixel(1'b0, (k == 0), img[k / W][k % W], 0, st);
        run_frame(1'b0, 0);
        wait_windows(1'b0, 2);
        check("resync err count", WW'(c_errs - err0), WW'(1));
        check("resync err timing", WW'(c_err_stamp), WW'(acc[0][0]));
        check_frame(1'b0, 2, "resync");

        // Reset mid-frame, then a clean frame
        c_q.delete();
        for (int k = 0; k < 8; k++) send_pixel(1'b0, (k == 0), img[k / W][k % W], 0, st);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst valid", WW'(c_ovalid), '0);
        check("midrst ready", WW'(c_ready), '0);
        check("midrst win", c_owin, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(1'b0, 0);
        wait_windows(1'b0, 2);
        check_frame(1'b0, 2, "postrst");
        if (c_q.size() == 2) begin
            check("postrst first", c_q[0].win, CROP_FIRST);
            check("postrst last", c_q[1].win, CROP_LAST);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 Parameter DATA_W, default 16: pixel width in bits.
REQ-002 Parameter IMG_W, default 640: pixels per line, minimum 3.
REQ-003 Parameter IMG_H, default 512: lines per frame, minimum 3.
REQ-004 Parameter BORDER_MODE, default 0: 0 = crop, giving (IMG_W-2)x(IMG_H-2) windows; 1 = zero-pad, giving IMG_W x IMG_H windows.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_sof, input, 1 bit: marks the first pixel of a frame; qualified by in_valid.
REQ-009 Port in_data, input, DATA_W bits: raster-order pixel.
REQ-010 Port in_ready, output, 1 bit: a pixel is accepted when in_valid and in_ready are both high.
REQ-011 Port out_valid, output, 1 bit: one-cycle window strobe.
REQ-012 Port out_sof / out_eol / out_eof, output, 1 bit each: first window of the frame / last window of a line / last window of the frame; valid only with out_valid.
REQ-013 Port out_win, output, 9*DATA_W bits: p11 in the LSBs through p33 in the MSBs, row-major; p22 is the centre; p1x is the line above the centre, p3x the line below.
REQ-014 Port err, output, 1 bit: one-cycle pulse on a protocol error.

Function
REQ-015 The FSM has four states: IDLE, RUN, COL_FLUSH and ROW_FLUSH.
REQ-016 IDLE: in_ready=1; accepted pixels without in_sof are dropped silently; an accepted in_sof pixel is taken as position (0,0) and the FSM goes to RUN.
REQ-017 RUN: in_ready=1; each accepted pixel advances the column, and the line after column IMG_W-1.
REQ-018 Gaps in in_valid stall the block with no other effect.
REQ-019 Two line buffers, each IMG_W deep and DATA_W wide, hold the previous two lines; a 3x3 register window shifts once per processed position.
REQ-020 Zero-pad mode: after column IMG_W-1 of each line the FSM spends 1 cycle in COL_FLUSH with in_ready=0, processing virtual column IMG_W.
REQ-021 Zero-pad mode: after the last line the FSM spends IMG_W+1 cycles in ROW_FLUSH with in_ready=0, processing virtual line IMG_H, then returns to IDLE.
REQ-022 Crop mode: after the last pixel of the frame the FSM returns directly to IDLE; COL_FLUSH and ROW_FLUSH are never entered.
REQ-023 The window centred at (r,c) is output with out_valid=1 exactly one cycle after position (r+1,c+1) is processed (real or virtual).
REQ-024 Crop mode outputs centres r=1..IMG_H-2, c=1..IMG_W-2; zero-pad mode outputs centres r=0..IMG_H-1, c=0..IMG_W-1.
REQ-025 Zero-pad mode: every tap outside the image is 0, including stale line-buffer contents from an earlier frame.
REQ-026 out_sof is set on the first window of the frame.
REQ-027 out_eol is set on the window at the last output column.
REQ-028 out_eof is set on the window at the last output line and column.
REQ-029 in_sof accepted in RUN is an error: err pulses the next cycle, the current frame is abandoned with no further out_valid for it, and the pixel restarts as (0,0) of a new frame.
REQ-030 out_win holds its last value while out_valid=0.
REQ-031 No downstream backpressure exists; the consumer accepts every out_valid.
REQ-032 All outputs are registered.

Reset
REQ-033 On rst: FSM=IDLE, counters=0, window registers=0; in_ready=0 while rst is asserted, then 1 from the first clock edge after release.
REQ-034 On rst: out_valid, out_sof, out_eol, out_eof and err are 0 and out_win is 0.
REQ-035 Line-buffer RAM is not cleared; zero-pad masking (REQ-025) makes stale contents invisible.
REQ-036 rst mid-frame discards the frame: no out_valid until a new in_sof frame produces one.

Verification (IMG_W=4, IMG_H=3, DATA_W=8, pixel(r,c)=10r+c, continuous in_valid unless stated)
REQ-037 Crop mode, one frame: exactly 2 windows. Window 1 (centre 11) appears one cycle after pixel 22 with p11=0, p22=11, p33=22 and out_sof=1. Window 2 (centre 12) has out_eol=1 and out_eof=1.
REQ-038 Zero-pad mode, one frame: exactly 12 windows. The first has p11..p21=0, p22=0, p23=1, p32=10, p33=11. in_ready is low 1 cycle after each line and 5 cycles after the last line. The last window (centre 23) has p23=p31..p33=0 and out_eof=1.
REQ-039 Same as REQ-038 with in_valid toggling 1,0,0,1,...: identical window contents and flags; only timing is stretched.
REQ-040 Two back-to-back zero-pad frames, the second with pixel=200+10r+c: every border tap of the second frame is 0 and no value from the first frame appears.
REQ-041 in_sof reasserted at pixel (1,2) in crop mode: err pulses once, and the next 12 pixels yield the 2 correct windows of the new frame.
REQ-042 rst pulsed after pixel (1,3), then a full frame: no output before the new frame, then the REQ-037 results exactly.
